// File: rtl/dd_arbiter_pkg.sv
// Shared definitions for the double-dabble request arbiter: FSM state
// encodings, response codes and small width helpers.
package dd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } dd_state_e;

    // Value carried on err alongside a done pulse.
    localparam logic RSP_OK      = 1'b0;
    localparam logic RSP_TIMEOUT = 1'b1;

    localparam int DATA_W = 32;

    // Index width for a pool of n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Timeout counter width.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/dd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last_owner+1, wrapping around, so last_owner itself is checked last.
module rr_pick
    import dd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OW-1:0]      last_owner,
    output logic [OW-1:0]      winner,
    output logic               any_req
);

    // Walk the requesters in priority order starting just after the last owner.
    always_comb begin
        logic          found;
        logic [OW-1:0] idx;
        found   = 1'b0;
        idx     = '0;
        winner  = '0;
        any_req = |req;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = OW'((int'(last_owner) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dd_arbiter.sv
// Arbiter sharing one external binary-to-BCD engine between NUM_REQ
// requesters. One conversion is in flight at a time; the engine is reached
// through the dd_* ports.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | no conversion in flight; pick a winner when any req is high
//   ST_ARM    | one-cycle blanking after dd_start; dd_done ignored (stale)
//   ST_WAIT   | waiting for dd_done, timeout counter running
//   ST_FINISH | result/err settled; pulse done[owner] and return to idle
module dd_arbiter
    import dd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         result,
    output logic                      err,
    output logic                      busy,
    output logic [DATA_W-1:0]         dd_input,
    output logic                      dd_start,
    input  logic [DATA_W-1:0]         dd_output,
    input  logic                      dd_done
);

    localparam int OW = idx_width(NUM_REQ);
    localparam int CW = cnt_width(TIMEOUT);
    // Counter value at which an unanswered WAIT gives up.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [OW-1:0] OWNER_RST = OW'(NUM_REQ - 1);

    dd_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [DATA_W-1:0]    result_q, result_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic [DATA_W-1:0]    dd_input_q, dd_input_d;
    logic                 dd_start_q, dd_start_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        last_owner_q, last_owner_d;

    logic [OW-1:0]        winner;
    logic                 any_req;
    logic [CW-1:0]        cnt_inc;
    logic [DATA_W-1:0]    op_arr [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_op
        assign op_arr[k] = req_data[DATA_W*k +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign cnt_inc = cnt_q + CW'(1);

    // Next-state and next-output logic for the conversion sequencer.
    always_comb begin
        state_d      = state_q;
        grant_d      = '0;
        done_d       = '0;
        dd_start_d   = 1'b0;
        result_d     = result_q;
        err_d        = err_q;
        dd_input_d   = dd_input_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d[winner] = 1'b1;
                    dd_input_d      = op_arr[winner];
                    dd_start_d      = 1'b1;
                    owner_d         = winner;
                    last_owner_d    = winner;
                    state_d         = ST_ARM;
                end
            end
            ST_ARM: begin
                // dd_done here may be left over from a previous conversion.
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dd_done) begin
                    result_d = dd_output;
                    err_d    = RSP_OK;
                    state_d  = ST_FINISH;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        result_d = '0;
                        err_d    = RSP_TIMEOUT;
                        state_d  = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                done_d[owner_q] = 1'b1;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset abandons any conversion in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            done_q       <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            dd_input_q   <= '0;
            dd_start_q   <= 1'b0;
            cnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= OWNER_RST;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            result_q     <= result_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            dd_input_q   <= dd_input_d;
            dd_start_q   <= dd_start_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign result   = result_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign dd_input = dd_input_q;
    assign dd_start = dd_start_q;

endmodule

// File: doc/dd_arbiter.md
DD_ARBITER -- requirements
Module: dd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one binary-to-BCD engine (2..8).
REQ-002 Parameter TIMEOUT, default 64: maximum cycles to wait for engine completion before aborting.
REQ-003 Port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 Port resetn  input  1  reset, asynchronous and active-low.
REQ-005 Port req  input  NUM_REQ  per-requester conversion request level.
REQ-006 Port req_data  input  32*NUM_REQ  per-requester binary operand; requester k uses bits [32k+31:32k].
REQ-007 Port grant  output  NUM_REQ  one-cycle pulse: the request has been accepted.
REQ-008 Port done  output  NUM_REQ  one-cycle pulse: the result for this requester is valid.
REQ-009 Port result  output  32  BCD result of the most recent conversion; held until the next done.
REQ-010 Port err  output  1  high with done when the conversion timed out.
REQ-011 Port busy  output  1  high whenever the state is not IDLE.
REQ-012 Port dd_input  output  32  operand sent to the engine.
REQ-013 Port dd_start  output  1  one-cycle engine start strobe.
REQ-014 Port dd_output  input  32  engine BCD result.
REQ-015 Port dd_done  input  1  engine completion indicator.

Function
REQ-016 The FSM SHALL have four states: IDLE, ARM, WAIT and FINISH.
REQ-017 IDLE with any req bit high: next cycle, grant the winner, latch its operand into dd_input, pulse dd_start and grant[winner] together, record the owner, and go to ARM.
REQ-018 The winner SHALL be picked round-robin: first set req bit searching upward (with wrap) from last_owner+1; last_owner resets to NUM_REQ-1, so index 0 wins first after reset.
REQ-019 ARM SHALL last exactly one cycle, ignore dd_done (blanking for stale engine done), and go to WAIT.
REQ-020 In WAIT, dd_done high: latch result from dd_output, clear err, and go to FINISH.
REQ-021 In WAIT, the timeout counter SHALL count cycles from entry into WAIT.
REQ-022 Timeout: when the counter reaches TIMEOUT-1 with dd_done low, set result to 0 and err to 1, and go to FINISH.
REQ-023 FINISH SHALL pulse done[owner] for one cycle, with err valid in that same cycle, and return to IDLE.
REQ-024 Minimum request-to-done latency SHALL be 4 cycles: grant at +1, ARM at +2, dd_done seen at +3, done at +4.
REQ-025 dd_done seen in IDLE or FINISH SHALL be ignored.
REQ-026 A requester SHALL hold req and req_data until grant; req dropped before grant means the request is not served.
REQ-027 A req still high in IDLE after its done SHALL be treated as a new request, subject to round-robin.
REQ-028 Simultaneous requests SHALL be granted one per conversion; at most one grant bit and one done bit are high in any cycle.
REQ-029 Changes to req_data after grant SHALL NOT affect the conversion in flight.
REQ-030 Counter width SHALL be clog2(TIMEOUT)+1.
REQ-031 Owner and last_owner width SHALL be clog2(NUM_REQ), minimum 1.

Reset
REQ-032 On resetn low, the block SHALL enter IDLE asynchronously.
REQ-033 Reset values: grant, done, dd_start, err and busy 0; result and dd_input 0; counter 0; last_owner NUM_REQ-1.
REQ-034 Reset mid-conversion SHALL abandon the conversion: no done pulse, and any later dd_done is ignored per REQ-025.

Structure
REQ-035 FSM state encodings and the response-code constants SHALL live in the shared project include.
REQ-036 The round-robin selection SHALL be a combinational sub-module rr_pick with inputs req and last_owner and outputs winner index and any_req.
REQ-037 The double_dabble engine SHALL be instantiated outside this block and connected through the dd_* ports.

Verification
REQ-038 Single request: req[0] with 0x000004D2, engine model returning after 10 cycles -> grant[0] at +1, done[0] with result 0x00001234, err 0.
REQ-039 Simultaneous requests: all four req bits raised together in one cycle after reset, each dropped on its grant -> grants in order 0,1,2,3, with done order and results matching per-requester operands.
REQ-040 Fairness: req[0] and req[2] held continuously -> grant sequence 0,2,0,2,...; requesters 1 and 3 are never granted.
REQ-041 Timeout: engine model never asserts dd_done, TIMEOUT=64 -> done[owner] exactly 64 cycles after WAIT entry, err 1, result 0, and the next request is served normally.
REQ-042 Maximum value: operand 0x05F5E0FF (99,999,999) -> result 0x99999999.
REQ-043 Stale done: dd_done held high during ARM -> result not captured until dd_done is seen in WAIT.
REQ-044 Reset mid-WAIT -> busy goes 0 immediately; a later dd_done produces no done pulse.
